instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit: credit-based instruction prefetch queue with redirect flush
// Revision: 1.0
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(QUEUE_DEPTH);

  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("QUEUE_DEPTH must be a power of 2 and at least 2");
  end

  logic              active;
  logic [31:0]       fetch_pc;
  logic [31:0]       resp_pc;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  q_count;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [31:0]       q_instr [QUEUE_DEPTH];
  logic [31:0]       q_pc    [QUEUE_DEPTH];

  logic              req_fire;
  logic              out_fire;
  logic              push;
  logic [CNT_W-1:0]  inflight_next;
  logic [SUM_W-1:0]  credit_used;
  logic [31:0]       redirect_target;

  // Every outstanding request owns a queue slot, so the queue can never overflow.
  assign credit_used     = {1'b0, inflight} + {1'b0, q_count};
  assign imem_req_valid  = active && (credit_used < DEPTH_SUM);
  assign imem_req_addr   = fetch_pc;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign out_valid       = (q_count != '0);
  assign out_fire        = out_valid && out_ready;
  assign push            = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
  assign inflight_next   = inflight + CNT_W'(req_fire) - CNT_W'(imem_resp_valid);
  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign out_instr       = q_instr[rd_ptr];
  assign out_pc          = q_pc[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      q_count  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      active   <= 1'b1;
      inflight <= inflight_next;
      if (redirect_valid) begin
        // Everything still in flight, including this cycle's request, is stale.
        fetch_pc <= redirect_target;
        resp_pc  <= redirect_target;
        drop_cnt <= inflight_next;
        q_count  <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push) resp_pc <= resp_pc + 32'd4;
        if (imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
        q_count <= q_count + CNT_W'(push) - CNT_W'(out_fire);
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (out_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= imem_resp_data;
      q_pc[wr_ptr]    <= resp_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// tb_instr_fetch_unit: directed and randomized checks of instr_fetch_unit
// against an in-order variable-latency memory model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int mem_mode = 0;
  int lat_min = 1;
  int lat_max = 1;
  int max_pend = 0;
  logic [31:0] pend_addr [$];
  int          pend_due  [$];

  instr_fetch_unit #(.RESET_PC(32'h0000_3000), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  // Memory: mode 0 ready always, 1 random ready, 2 never ready; in-order responses.
  initial begin : mem_model
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      imem_resp_valid = 1'b0;
      if (!rst_n) begin
        pend_addr.delete();
        pend_due.delete();
        imem_req_ready = 1'b0;
      end else begin
        if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = word_of(pend_addr[0]);
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end
        case (mem_mode)
          0:       imem_req_ready = 1'b1;
          1:       imem_req_ready = 1'($urandom_range(1, 0));
          default: imem_req_ready = 1'b0;
        endcase
        if (imem_req_valid && imem_req_ready) begin
          pend_addr.push_back(imem_req_addr);
          pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
          if (pend_addr.size() > max_pend) max_pend = pend_addr.size();
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int mode, input int lmin, input int lmax, input logic ordy);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = ordy;
    mem_mode       = mode;
    lat_min        = lmin;
    lat_max        = lmax;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(0, 1, 1, 1'b0);
    rst_n = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid: got %b, expected 0", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 32'h3000) begin n_bad++; $display("FAIL rst_req_addr: got %h, expected 00003000", imem_req_addr); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL first_req_valid: got %b, expected 1", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 32'h3000) begin n_bad++; $display("FAIL first_req_addr: got %h, expected 00003000", imem_req_addr); end
    repeat (4) tick();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL prefill_valid: got %b, expected 1", out_valid); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL async_out_valid: got %b, expected 0", out_valid); end
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL async_req_valid: got %b, expected 0", imem_req_valid); end
    n_cmp++; if (imem_req_addr !== 32'h3000) begin n_bad++; $display("FAIL async_req_addr: got %h, expected 00003000", imem_req_addr); end
  endtask

  task automatic test_stream();
    logic        exp_v;
    logic [31:0] exp_a;
    logic [31:0] exp_pc;
    do_reset(0, 1, 1, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp_v = (k >= 3);
      exp_a = 32'h3000 + 32'(4 * (k - 1));
      n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL stream_req_valid k=%0d: got %b, expected 1", k, imem_req_valid); end
      n_cmp++; if (imem_req_addr !== exp_a) begin n_bad++; $display("FAIL stream_addr k=%0d: got %h, expected %h", k, imem_req_addr, exp_a); end
      n_cmp++; if (out_valid !== exp_v) begin n_bad++; $display("FAIL stream_out_valid k=%0d: got %b, expected %b", k, out_valid, exp_v); end
      if (k >= 3) begin
        exp_pc = 32'h3000 + 32'(4 * (k - 3));
        n_cmp++; if (out_pc !== exp_pc) begin n_bad++; $display("FAIL stream_pc k=%0d: got %h, expected %h", k, out_pc, exp_pc); end
        n_cmp++; if (out_instr !== word_of(exp_pc)) begin n_bad++; $display("FAIL stream_instr k=%0d: got %h, expected %h", k, out_instr, word_of(exp_pc)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic        exp_v;
    logic [31:0] exp_pc;
    do_reset(0, 1, 1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_v = (k <= 4);
      n_cmp++; if (imem_req_valid !== exp_v) begin n_bad++; $display("FAIL bp_req_valid k=%0d: got %b, expected %b", k, imem_req_valid, exp_v); end
      if (k >= 5) begin
        n_cmp++; if (imem_req_addr !== 32'h3010) begin n_bad++; $display("FAIL bp_addr_hold k=%0d: got %h, expected 00003010", k, imem_req_addr); end
        n_cmp++; if (out_pc !== 32'h3000) begin n_bad++; $display("FAIL bp_pc_hold k=%0d: got %h, expected 00003000", k, out_pc); end
      end
    end
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      exp_pc = 32'h3004 + 32'(4 * j);
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_drain_valid j=%0d: got %b, expected 1", j, out_valid); end
      n_cmp++; if (out_pc !== exp_pc) begin n_bad++; $display("FAIL bp_drain_pc j=%0d: got %h, expected %h", j, out_pc, exp_pc); end
      if (j == 0) begin
        n_cmp++; if (imem_req_valid !== 1'b1) begin n_bad++; $display("FAIL bp_resume_valid: got %b, expected 1", imem_req_valid); end
      end
    end
  endtask

  task automatic test_redirect();
    bit seen;
    do_reset(0, 4, 4, 1'b1);
    tick();
    tick();
    mem_mode = 2;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_4001;
    tick();
    redirect_valid = 1'b0;
    mem_mode       = 0;
    n_cmp++; if (imem_req_addr !== 32'h4000) begin n_bad++; $display("FAIL redir_addr: got %h, expected 00004000", imem_req_addr); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL redir_flushed: got %b, expected 0", out_valid); end
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      tick();
      seen = out_valid;
    end
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL redir_timeout: got no output, expected out_pc 00004000"); end
    else if (out_pc !== 32'h4000) begin n_bad++; $display("FAIL redir_first_pc: got %h, expected 00004000", out_pc); end
    tick();
    n_cmp++; if (out_pc !== 32'h4004 || out_valid !== 1'b1) begin n_bad++; $display("FAIL redir_second_pc: got %h valid %b, expected 00004004 valid 1", out_pc, out_valid); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_pc;
    do_reset(0, 1, 1, 1'b1);
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_8000;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (imem_req_addr !== 32'h8000) begin n_bad++; $display("FAIL same_addr: got %h, expected 00008000", imem_req_addr); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL same_flush: got %b, expected 0", out_valid); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL same_stale_dropped: got valid %b pc %h, expected valid 0", out_valid, out_pc); end
    for (int j = 0; j < 3; j++) begin
      tick();
      exp_pc = 32'h8000 + 32'(4 * j);
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin n_bad++; $display("FAIL same_pc j=%0d: got %h valid %b, expected %h valid 1", j, out_pc, out_valid, exp_pc); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    do_reset(0, 1, 1, 1'b1);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    n_cmp++; if (imem_req_addr !== 32'hFFFF_FFF8) begin n_bad++; $display("FAIL wrap_target: got %h, expected fffffff8", imem_req_addr); end
    tick();
    for (int k = 4; k <= 7; k++) begin
      tick();
      exp_pc = 32'hFFFF_FFF8 + 32'(4 * (k - 4));
      if (k == 4) begin
        n_cmp++; if (imem_req_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_addr: got %h, expected 00000000", imem_req_addr); end
      end
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== exp_pc) begin n_bad++; $display("FAIL wrap_pc k=%0d: got %h valid %b, expected %h valid 1", k, out_pc, out_valid, exp_pc); end
      n_cmp++; if (out_instr !== word_of(exp_pc)) begin n_bad++; $display("FAIL wrap_instr k=%0d: got %h, expected %h", k, out_instr, word_of(exp_pc)); end
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    int          pops;
    do_reset(1, 1, 5, 1'b0);
    exp_pc = 32'h3000;
    pops   = 0;
    for (int t = 0; t < 1500; t++) begin
      tick();
      out_ready = 1'($urandom_range(1, 0));
      if (out_valid && out_ready) begin
        pops++;
        n_cmp++; if (out_pc !== exp_pc || out_instr !== word_of(exp_pc)) begin n_bad++; $display("FAIL rand_pc t=%0d: got %h/%h, expected %h/%h", t, out_pc, out_instr, exp_pc, word_of(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect_valid) begin
        redirect_valid = 1'b0;
      end else if ($urandom_range(15, 0) == 0) begin
        redirect_pc    = $urandom;
        redirect_valid = 1'b1;
        exp_pc         = {redirect_pc[31:2], 2'b00};
      end
    end
    n_cmp++; if (pops < 50) begin n_bad++; $display("FAIL rand_progress: got %0d pops, expected at least 50", pops); end
    n_cmp++; if (max_pend > 4) begin n_bad++; $display("FAIL max_inflight: got %0d, expected at most 4", max_pend); end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    rst_n          = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_same_cycle();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
